// File: rtl/universal_shift_reg_if.sv
// Control/data bundle of the universal shift register: mode controls and load data in, register state out.
// master drives the controls; slave is the register itself.
interface universal_shift_reg_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH);

    logic             en;
    logic             sync_clr;
    logic [1:0]       mode;
    logic             ser_in_r;
    logic             ser_in_l;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] _Q;
    logic             ser_out_r;
    logic             ser_out_l;
    logic [CW-1:0]    shift_cnt;
    logic             word_done;

    modport master (
        output en, sync_clr, mode, ser_in_r, ser_in_l, D,
        input  Q, _Q, ser_out_r, ser_out_l, shift_cnt, word_done
    );

    modport slave (
        input  en, sync_clr, mode, ser_in_r, ser_in_l, D,
        output Q, _Q, ser_out_r, ser_out_l, shift_cnt, word_done
    );
endinterface

// File: rtl/universal_shift_reg.sv
// Universal register (hold / shift right / shift left / load) with a shift counter that pulses word_done every WIDTH shifts.
// Latency 1 cycle for Q, shift_cnt and word_done; no backpressure, en=0 freezes state.
module universal_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    universal_shift_reg_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             shift;

    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        shift  = 1'b0;
        if (bus.sync_clr) begin
            q_d   = RESET_VAL;
            cnt_d = '0;
        end else if (bus.en) begin
            case (bus.mode)
                MODE_SHR: begin
                    q_d   = {bus.ser_in_r, q_q[WIDTH-1:1]};
                    shift = 1'b1;
                end
                MODE_SHL: begin
                    q_d   = {q_q[WIDTH-2:0], bus.ser_in_l};
                    shift = 1'b1;
                end
                MODE_LOAD: begin
                    q_d   = bus.D;
                    cnt_d = '0;
                end
                MODE_HOLD: q_d = q_q;
                default:   q_d = q_q;
            endcase
            // Both directions advance the same count; the wrap edge raises the pulse.
            if (shift) begin
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q    <= RESET_VAL;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bus.Q         = q_q;
    assign bus._Q        = ~q_q;
    assign bus.ser_out_r = q_q[0];
    assign bus.ser_out_l = q_q[WIDTH-1];
    assign bus.shift_cnt = cnt_q;
    assign bus.word_done = done_q;
endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench: an 8-bit register with zero reset value and a 4-bit register with reset value 4'hA share clock and reset.
module tb_universal_shift_reg;
    logic clk;
    logic reset_n;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses;

    bit         exp_ser[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] exp6_q[4]  = '{4'h5, 4'hB, 4'h7, 4'hF};
    logic [1:0] exp6_c[4]  = '{2'd1, 2'd2, 2'd3, 2'd0};

    universal_shift_reg_if #(.WIDTH(8)) a ();
    universal_shift_reg_if #(.WIDTH(4)) b ();

    universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (a)
    );

    universal_shift_reg #(.WIDTH(4), .RESET_VAL(4'b1010)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        a.en = 1'b0; a.sync_clr = 1'b0; a.mode = 2'b00; a.ser_in_r = 1'b0; a.ser_in_l = 1'b0; a.D = '0;
        b.en = 1'b0; b.sync_clr = 1'b0; b.mode = 2'b00; b.ser_in_r = 1'b0; b.ser_in_l = 1'b0; b.D = '0;
        reset_n = 1'b0;
        step;
        step;
        chk_eq("rst_q",   a.Q, 8'h00);
        chk_eq("rst_nq",  a._Q, 8'hFF);
        chk_eq("rst_cnt", a.shift_cnt, 0);
        chk_eq("rst_wd",  a.word_done, 0);
        chk_eq("rst4_q",  b.Q, 4'hA);
        reset_n = 1'b1;

        // Load A5 and shift it out to the right.
        a.en = 1'b1; a.mode = 2'b11; a.D = 8'hA5;
        step;
        chk_eq("ld_q",   a.Q, 8'hA5);
        chk_eq("ld_nq",  a._Q, 8'h5A);
        chk_eq("ld_sol", a.ser_out_l, 1);
        chk_eq("ld_cnt", a.shift_cnt, 0);
        a.mode = 2'b01; a.ser_in_r = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_eq($sformatf("sr_out%0d", i), a.ser_out_r, exp_ser[i]);
            step;
            chk_eq($sformatf("sr_wd%0d", i), a.word_done, (i == 7) ? 1 : 0);
        end
        chk_eq("sr_q",   a.Q, 8'h00);
        chk_eq("sr_cnt", a.shift_cnt, 0);
        a.mode = 2'b00;
        step;
        chk_eq("sr_wd_end", a.word_done, 0);

        // Load 81, three left shifts of 1, then five stalled cycles.
        a.mode = 2'b11; a.D = 8'h81;
        step;
        a.mode = 2'b10; a.ser_in_l = 1'b1;
        repeat (3) step;
        chk_eq("sl_q",   a.Q, 8'h0F);
        chk_eq("sl_cnt", a.shift_cnt, 3);
        a.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step;
            chk_eq($sformatf("stall_q%0d", i),   a.Q, 8'h0F);
            chk_eq($sformatf("stall_cnt%0d", i), a.shift_cnt, 3);
            chk_eq($sformatf("stall_wd%0d", i),  a.word_done, 0);
        end

        // Four right shifts of 1, then clear wins over a disabled load.
        a.en = 1'b1; a.mode = 2'b01; a.ser_in_r = 1'b1;
        repeat (4) step;
        chk_eq("sr4_q",   a.Q, 8'hF0);
        chk_eq("sr4_cnt", a.shift_cnt, 7);
        a.sync_clr = 1'b1; a.en = 1'b0; a.mode = 2'b11; a.D = 8'hFF;
        step;
        chk_eq("clr_q",   a.Q, 8'h00);
        chk_eq("clr_cnt", a.shift_cnt, 0);
        chk_eq("clr_wd",  a.word_done, 0);
        a.sync_clr = 1'b0; a.en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a.mode = (i % 2 == 1) ? 2'b10 : 2'b01;
            step;
            chk_eq($sformatf("mix_wd%0d", i), a.word_done, (i == 7) ? 1 : 0);
        end
        chk_eq("mix_cnt", a.shift_cnt, 0);

        // Sixteen continuous shifts: two pulses, eight cycles apart.
        a.mode = 2'b01;
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            step;
            if (a.word_done === 1'b1) pulses++;
            chk_eq($sformatf("cont_wd%0d", i), a.word_done, (i == 7 || i == 15) ? 1 : 0);
        end
        chk_eq("cont_pulses", pulses, 2);

        // Load on the fifth cycle of a word restarts the count.
        repeat (4) step;
        chk_eq("pre_ld_cnt", a.shift_cnt, 4);
        a.mode = 2'b11; a.D = 8'h3C;
        step;
        chk_eq("mid_ld_q",   a.Q, 8'h3C);
        chk_eq("mid_ld_cnt", a.shift_cnt, 0);
        chk_eq("mid_ld_wd",  a.word_done, 0);
        a.mode = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            step;
            chk_eq($sformatf("post_ld_wd%0d", k), a.word_done, (k == 8) ? 1 : 0);
        end

        // Asynchronous reset in mid-operation, away from any clock edge.
        a.mode = 2'b10; a.ser_in_l = 1'b0;
        repeat (3) step;
        chk_eq("pre_rst_cnt", a.shift_cnt, 3);
        reset_n = 1'b0;
        #1;
        chk_eq("arst_q",   a.Q, 8'h00);
        chk_eq("arst_nq",  a._Q, 8'hFF);
        chk_eq("arst_cnt", a.shift_cnt, 0);
        chk_eq("arst_wd",  a.word_done, 0);
        chk_eq("arst4_q",  b.Q, 4'hA);
        step;
        chk_eq("arst_hold_q", a.Q, 8'h00);
        reset_n = 1'b1;
        a.mode = 2'b00;

        // Four-bit register: four left shifts of 1 from 4'hA.
        b.en = 1'b1; b.mode = 2'b10; b.ser_in_l = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step;
            chk_eq($sformatf("w4_q%0d", i),   b.Q, exp6_q[i]);
            chk_eq($sformatf("w4_cnt%0d", i), b.shift_cnt, exp6_c[i]);
            chk_eq($sformatf("w4_wd%0d", i),  b.word_done, (i == 3) ? 1 : 0);
        end
        b.mode = 2'b00;
        step;
        chk_eq("w4_hold_q",  b.Q, 4'hF);
        chk_eq("w4_hold_wd", b.word_done, 0);
        chk_eq("w4_nq",      b._Q, 4'h0);
        chk_eq("a_after_rst", a.Q, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
Parametrised universal register: a WIDTH-bit bank of rising-edge D flip-flops with asynchronous active-low reset. It supports hold, shift right, shift left and parallel load, with serial ins/outs and a true/complement output pair. A shift counter pulses word_done after every WIDTH consecutive shifts. It is the building block for serializers/deserializers and for the counter and sequence-detector exercises.

Parameters:
WIDTH, 8, register width in bits; legal range 2..32.
RESET_VAL, {WIDTH{1'b0}}, value loaded into Q by reset_n and by sync_clr.
CW, $clog2(WIDTH), derived localparam; width of shift_cnt; not overridden by users.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset_n  input  1  asynchronous active-low reset.
en  input  1  clock enable for mode operations; 0 holds all state (sync_clr still acts).
sync_clr  input  1  synchronous clear: Q<=RESET_VAL, shift_cnt<=0.
mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
ser_in_r  input  1  bit entering Q[WIDTH-1] on shift right.
ser_in_l  input  1  bit entering Q[0] on shift left.
D  input  WIDTH  parallel load data.
Q  output  WIDTH  register contents.
_Q  output  WIDTH  bitwise complement of Q (combinational, ~Q).
ser_out_r  output  1  Q[0] (combinational).
ser_out_l  output  1  Q[WIDTH-1] (combinational).
shift_cnt  output  CW  shifts completed since last load/clear/wrap.
word_done  output  1  registered one-cycle pulse after the WIDTH-th shift.

Behaviour:
- reset_n=0 (asynchronous, no clk needed): Q=RESET_VAL, shift_cnt=0, word_done=0 immediately; held while low. Deassertion is synchronous to the next rising clk; the first update occurs on the first edge with reset_n=1.
- Reset acts mid-operation; any partial shift count is discarded.
- Priority per edge: reset_n > sync_clr > en > mode.
- sync_clr=1: Q<=RESET_VAL, shift_cnt<=0, word_done<=0; ignores en and mode.
- en=0 (no clr): Q and shift_cnt hold; word_done<=0.
- en=1, mode=00: hold; word_done<=0.
- en=1, mode=01: Q<={ser_in_r, Q[WIDTH-1:1]}.
- en=1, mode=10: Q<={Q[WIDTH-2:0], ser_in_l}.
- en=1, mode=11: Q<=D, shift_cnt<=0, word_done<=0.
- Counter, on each shift (mode 01 or 10, en=1, no clr):
  - if shift_cnt==WIDTH-1: shift_cnt<=0, word_done<=1;
  - else shift_cnt<=shift_cnt+1, word_done<=0.
  - Left and right shifts count alike; a direction change does not reset the count.
- word_done is high for exactly one cycle per WIDTH shifts. Back-to-back words give a pulse every WIDTH cycles. Intervening hold/en=0 cycles stretch the count but never the pulse.
- No X propagation: all state is defined after reset. Only D/ser_in values in X produce X in Q.
- Latency: a Q change is visible 1 cycle after the sampling edge. _Q and ser_out_* follow Q combinationally.

Test Plan:
1. WIDTH=8; reset_n low mid-simulation with no clk edge -> Q=8'h00 and _Q=8'hFF within the same timestep; shift_cnt=0, word_done=0.
2. Load D=8'hA5 (mode 11), then 8 right shifts with ser_in_r=0 -> ser_out_r sequence 1,0,1,0,0,1,0,1; Q=8'h00 after the 8th; word_done=1 on exactly the cycle after the 8th shift; shift_cnt back to 0.
3. Load 8'h81, then 3 left shifts with ser_in_l=1 -> Q=8'h0F, shift_cnt=3. Then en=0 for 5 cycles -> Q and shift_cnt unchanged, word_done=0.
4. 4 right shifts, then sync_clr=1 with en=0 and mode=11, D=8'hFF -> Q=8'h00 (clr wins), shift_cnt=0. Next 8 shifts give word_done only after the 8th.
5. Continuous 16 shifts -> word_done pulses exactly twice, 8 cycles apart; a parallel load at shift 5 of the second word resets the count so the next pulse comes 8 shifts after the load.
6. WIDTH=4, RESET_VAL=4'b1010 -> after reset Q=4'hA. After 4 left shifts with ser_in_l=1, Q=4'hF and word_done pulses; shift_cnt is 2 bits wide.
